// File: rtl/cmpt_step_dispatch_pkg.sv
// Shared types and defaults for the CartPole step dispatcher and its env slots.
package cmpt_step_dispatch_pkg;

  localparam int PE_NUM_DEF    = 20;
  localparam int STA_WL_DEF    = 128;
  localparam int ACT_WL_DEF    = 1;
  localparam int RWD_WL_DEF    = 1;
  localparam int MAX_STEPS_DEF = 500;
  localparam int TMO_CYC_DEF   = 64;

  // Dispatcher FSM encodings.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUB      = 3'd1,
    ST_WAIT_ACT = 3'd2,
    ST_LAUNCH   = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_ERR      = 3'd5
  } fsm_state_e;

  // FP32 field order of one state word, MSB first: {x, x_dot, theta, theta_dot}.
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] x_dot;
    logic [31:0] theta;
    logic [31:0] theta_dot;
  } cp_state_t;

endpackage

// File: rtl/cmpt_step_dispatch_env_slot.sv
// One environment slot: live state, last reward/done, episode length and the
// auto-reset mux that swaps in the seed state when an episode ends.
module cmpt_env_slot
  import cmpt_step_dispatch_pkg::*;
#(
  parameter int STA_WL    = STA_WL_DEF,
  parameter int RWD_WL    = RWD_WL_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_capture,
  input  logic [STA_WL-1:0] i_seed_sta,
  input  logic [STA_WL-1:0] i_cmpt_sta,
  input  logic [RWD_WL-1:0] i_cmpt_rwd,
  input  logic              i_cmpt_done,
  output logic [STA_WL-1:0] o_sta,
  output logic [RWD_WL-1:0] o_rwd,
  output logic              o_done
);

  localparam int EP_W = $clog2(MAX_STEPS + 1);

  logic [STA_WL-1:0] sta_q, sta_d;
  logic [RWD_WL-1:0] rwd_q, rwd_d;
  logic              done_q, done_d;
  logic [EP_W-1:0]   ep_len_q, ep_len_d;
  logic              trunc_s;
  logic              end_s;

  // Next-state: seed load on start, capture with truncation/auto-reset, else hold.
  always_comb begin
    sta_d    = sta_q;
    rwd_d    = rwd_q;
    done_d   = done_q;
    ep_len_d = ep_len_q;
    trunc_s  = (ep_len_q == EP_W'(MAX_STEPS - 1));
    end_s    = i_cmpt_done | trunc_s;
    if (i_load) begin
      sta_d    = i_seed_sta;
      rwd_d    = {RWD_WL{1'b0}};
      done_d   = 1'b0;
      ep_len_d = {EP_W{1'b0}};
    end else if (i_capture) begin
      rwd_d  = i_cmpt_rwd;
      done_d = end_s;
      if (end_s) begin
        sta_d    = i_seed_sta;
        ep_len_d = {EP_W{1'b0}};
      end else begin
        sta_d    = i_cmpt_sta;
        ep_len_d = ep_len_q + EP_W'(1);
      end
    end else begin
      sta_d = sta_q;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sta_q    <= {STA_WL{1'b0}};
      rwd_q    <= {RWD_WL{1'b0}};
      done_q   <= 1'b0;
      ep_len_q <= {EP_W{1'b0}};
    end else begin
      sta_q    <= sta_d;
      rwd_q    <= rwd_d;
      done_q   <= done_d;
      ep_len_q <= ep_len_d;
    end
  end

  assign o_sta  = sta_q;
  assign o_rwd  = rwd_q;
  assign o_done = done_q;

endmodule

// File: rtl/cmpt_step_dispatch.sv
// Agent-side dispatcher for the CartPole step Compute array: publishes the
// observation batch, takes an action batch, runs one Compute step with a
// response timeout, and captures results into the per-env slots.
module cmpt_step_dispatch
  import cmpt_step_dispatch_pkg::*;
#(
  parameter int PE_NUM    = PE_NUM_DEF,
  parameter int STA_WL    = STA_WL_DEF,
  parameter int ACT_WL    = ACT_WL_DEF,
  parameter int RWD_WL    = RWD_WL_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF,
  parameter int TMO_CYC   = TMO_CYC_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [PE_NUM*STA_WL-1:0] i_seed_sta,
  output logic                     o_obs_valid,
  input  logic                     i_obs_ready,
  output logic [PE_NUM*STA_WL-1:0] o_obs_sta,
  output logic [PE_NUM*RWD_WL-1:0] o_obs_rwd,
  output logic [PE_NUM-1:0]        o_obs_done,
  input  logic                     i_act_valid,
  output logic                     o_act_ready,
  input  logic [PE_NUM*ACT_WL-1:0] i_act,
  output logic                     o_cmpt_ena,
  output logic [PE_NUM*STA_WL-1:0] o_cmpt_sta,
  output logic [PE_NUM*ACT_WL-1:0] o_cmpt_act,
  input  logic [PE_NUM*STA_WL-1:0] i_cmpt_sta,
  input  logic [PE_NUM*RWD_WL-1:0] i_cmpt_rwd,
  input  logic [PE_NUM-1:0]        i_cmpt_done,
  input  logic                     i_cmpt_valid,
  output logic                     o_timeout,
  output logic [31:0]              o_step_cnt
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);

  fsm_state_e                fsm_q, fsm_d;
  logic                      obs_valid_q, obs_valid_d;
  logic                      act_ready_q, act_ready_d;
  logic                      cmpt_ena_q, cmpt_ena_d;
  logic                      timeout_q, timeout_d;
  logic [31:0]               step_cnt_q, step_cnt_d;
  logic [PE_NUM*ACT_WL-1:0]  act_q, act_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      load_s;
  logic                      capture_s;
  logic [PE_NUM*STA_WL-1:0]  sta_bank_s;

  // FSM next-state and registered-output decode.
  always_comb begin
    fsm_d       = fsm_q;
    obs_valid_d = obs_valid_q;
    act_ready_d = act_ready_q;
    cmpt_ena_d  = cmpt_ena_q;
    timeout_d   = timeout_q;
    step_cnt_d  = step_cnt_q;
    act_d       = act_q;
    tmo_d       = tmo_q;
    load_s      = 1'b0;
    capture_s   = 1'b0;
    case (fsm_q)
      ST_IDLE, ST_ERR: begin
        if (i_start) begin
          load_s      = 1'b1;
          fsm_d       = ST_PUB;
          obs_valid_d = 1'b1;
          act_ready_d = 1'b0;
          cmpt_ena_d  = 1'b0;
          timeout_d   = 1'b0;
          step_cnt_d  = 32'd0;
        end else begin
          fsm_d = fsm_q;
        end
      end
      ST_PUB: begin
        if (i_obs_ready) begin
          fsm_d       = ST_WAIT_ACT;
          obs_valid_d = 1'b0;
          act_ready_d = 1'b1;
        end else begin
          fsm_d = ST_PUB;
        end
      end
      ST_WAIT_ACT: begin
        if (i_act_valid) begin
          fsm_d       = ST_LAUNCH;
          act_d       = i_act;
          act_ready_d = 1'b0;
          cmpt_ena_d  = 1'b1;
        end else begin
          fsm_d = ST_WAIT_ACT;
        end
      end
      ST_LAUNCH: begin
        fsm_d = ST_WAIT_RES;
        tmo_d = {TMO_W{1'b0}};
      end
      ST_WAIT_RES: begin
        if (i_cmpt_valid) begin
          capture_s   = 1'b1;
          fsm_d       = ST_PUB;
          cmpt_ena_d  = 1'b0;
          obs_valid_d = 1'b1;
          step_cnt_d  = step_cnt_q + 32'd1;
        end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
          fsm_d      = ST_ERR;
          cmpt_ena_d = 1'b0;
          timeout_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        fsm_d       = ST_IDLE;
        obs_valid_d = 1'b0;
        act_ready_d = 1'b0;
        cmpt_ena_d  = 1'b0;
      end
    endcase
  end

  // FSM state and registered outputs, synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_q       <= ST_IDLE;
      obs_valid_q <= 1'b0;
      act_ready_q <= 1'b0;
      cmpt_ena_q  <= 1'b0;
      timeout_q   <= 1'b0;
      step_cnt_q  <= 32'd0;
      act_q       <= {(PE_NUM*ACT_WL){1'b0}};
      tmo_q       <= {TMO_W{1'b0}};
    end else begin
      fsm_q       <= fsm_d;
      obs_valid_q <= obs_valid_d;
      act_ready_q <= act_ready_d;
      cmpt_ena_q  <= cmpt_ena_d;
      timeout_q   <= timeout_d;
      step_cnt_q  <= step_cnt_d;
      act_q       <= act_d;
      tmo_q       <= tmo_d;
    end
  end

  for (genvar g = 0; g < PE_NUM; g++) begin : g_slot
    cmpt_env_slot #(
      .STA_WL    (STA_WL),
      .RWD_WL    (RWD_WL),
      .MAX_STEPS (MAX_STEPS)
    ) u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (load_s),
      .i_capture   (capture_s),
      .i_seed_sta  (i_seed_sta[g*STA_WL +: STA_WL]),
      .i_cmpt_sta  (i_cmpt_sta[g*STA_WL +: STA_WL]),
      .i_cmpt_rwd  (i_cmpt_rwd[g*RWD_WL +: RWD_WL]),
      .i_cmpt_done (i_cmpt_done[g]),
      .o_sta       (sta_bank_s[g*STA_WL +: STA_WL]),
      .o_rwd       (o_obs_rwd[g*RWD_WL +: RWD_WL]),
      .o_done      (o_obs_done[g])
    );
  end

  // The state bank only changes on load/capture, so Compute inputs stay held through WAIT_RES.
  assign o_obs_sta   = sta_bank_s;
  assign o_cmpt_sta  = sta_bank_s;
  assign o_cmpt_act  = act_q;
  assign o_obs_valid = obs_valid_q;
  assign o_act_ready = act_ready_q;
  assign o_cmpt_ena  = cmpt_ena_q;
  assign o_timeout   = timeout_q;
  assign o_step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_cmpt_step_dispatch.sv
// Directed bench for cmpt_step_dispatch with a behavioural Compute model of programmable latency.
module tb_cmpt_step_dispatch;
  import cmpt_step_dispatch_pkg::*;

  localparam int PE   = 20;
  localparam int SW   = 128;
  localparam int MAXS = 500;
  localparam int TMO  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, obs_ready, act_valid;
  logic [PE-1:0]     act;
  logic [PE*SW-1:0]  seed_vec, obs_sta, cmpt_sta, cm_sta;
  logic [PE-1:0]     obs_rwd, obs_done, cmpt_act, cm_rwd, cm_done;
  logic              obs_valid, act_ready, cmpt_ena, timeout, cm_valid;
  logic [31:0]       step_cnt;

  int                mdl_cnt;
  int                mdl_lat;
  logic              mdl_valid, mdl_en, force_valid;
  logic [PE-1:0]     mdl_rwd, mdl_done;

  logic [127:0]      seed_bank [PE];
  logic [127:0]      exp_sta   [PE];
  int                exp_len   [PE];
  logic [PE-1:0]     exp_rwd, exp_done;
  int                exp_cnt;
  int                n_tests = 0;
  int                n_fail  = 0;
  int                ena_cyc;
  logic              ok;

  cmpt_step_dispatch dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_seed_sta   (seed_vec),
    .o_obs_valid  (obs_valid),
    .i_obs_ready  (obs_ready),
    .o_obs_sta    (obs_sta),
    .o_obs_rwd    (obs_rwd),
    .o_obs_done   (obs_done),
    .i_act_valid  (act_valid),
    .o_act_ready  (act_ready),
    .i_act        (act),
    .o_cmpt_ena   (cmpt_ena),
    .o_cmpt_sta   (cmpt_sta),
    .o_cmpt_act   (cmpt_act),
    .i_cmpt_sta   (cm_sta),
    .i_cmpt_rwd   (cm_rwd),
    .i_cmpt_done  (cm_done),
    .i_cmpt_valid (cm_valid),
    .o_timeout    (timeout),
    .o_step_cnt   (step_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Toy CartPole step used by both the Compute model and the expectation model.
  function automatic logic [127:0] nxt(input logic [127:0] s, input logic a, input int g);
    return s + 128'(g + 1) + (a ? 128'h1_0000_0000 : 128'h0);
  endfunction

  for (genvar g = 0; g < PE; g++) begin : g_mdl
    assign cm_sta[g*SW +: SW] = nxt(cmpt_sta[g*SW +: SW], cmpt_act[g], g);
  end
  assign cm_rwd   = mdl_rwd;
  assign cm_done  = mdl_done;
  assign cm_valid = mdl_valid | force_valid;

  // Compute model: o_valid asserted mdl_lat cycles after enable first rises.
  always @(posedge clk) begin
    if (!cmpt_ena) begin
      mdl_cnt   <= 0;
      mdl_valid <= 1'b0;
    end else begin
      mdl_cnt   <= mdl_cnt + 1;
      mdl_valid <= mdl_en && ((mdl_cnt + 1) == mdl_lat);
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Compares the observed state bank against the model, reporting the first differing env.
  task automatic check_bank(input string tag);
    int idx;
    idx = 0;
    for (int g = PE - 1; g >= 0; g--) begin
      if (obs_sta[g*SW +: SW] !== exp_sta[g]) idx = g;
    end
    check_val($sformatf("%s_sta[%0d]", tag, idx), obs_sta[idx*SW +: SW], exp_sta[idx]);
  endtask

  task automatic check_obs(input string tag);
    check_bank(tag);
    check_val({tag, "_rwd"},  128'(obs_rwd),  128'(exp_rwd));
    check_val({tag, "_done"}, 128'(obs_done), 128'(exp_done));
    check_val({tag, "_cnt"},  128'(step_cnt), 128'(exp_cnt));
    check_val({tag, "_vld"},  128'(obs_valid), 128'd1);
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int g = 0; g < PE; g++) begin
      exp_sta[g] = seed_bank[g];
      exp_len[g] = 0;
    end
    exp_rwd  = '0;
    exp_done = '0;
    exp_cnt  = 0;
  endtask

  // From PUB: observation handshake then action handshake; returns at the LAUNCH cycle.
  task automatic hs_act(input logic [PE-1:0] a);
    obs_ready = 1'b1;
    @(negedge clk);
    obs_ready = 1'b0;
    act       = a;
    act_valid = 1'b1;
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic step(input logic [PE-1:0] a, input int lat, input logic [PE-1:0] rw,
                      input logic [PE-1:0] dn);
    logic d;
    mdl_lat  = lat;
    mdl_rwd  = rw;
    mdl_done = dn;
    mdl_en   = 1'b1;
    hs_act(a);
    ena_cyc = 0;
    ok      = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (cmpt_ena) ena_cyc++;
      if (obs_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_val("result_wait", 128'(ok), 128'd1);
    for (int g = 0; g < PE; g++) begin
      d = dn[g] | (exp_len[g] == MAXS - 1);
      exp_done[g] = d;
      exp_rwd[g]  = rw[g];
      if (d) begin
        exp_sta[g] = seed_bank[g];
        exp_len[g] = 0;
      end else begin
        exp_sta[g] = nxt(exp_sta[g], a[g], g);
        exp_len[g] = exp_len[g] + 1;
      end
    end
    exp_cnt++;
  endtask

  initial begin
    logic [PE*SW-1:0] snap;
    logic             stable;
    int               k_to;
    cp_state_t        s0;

    rst = 1'b1; start = 1'b0; obs_ready = 1'b0; act_valid = 1'b0; act = '0;
    mdl_en = 1'b1; mdl_lat = 1; mdl_rwd = '0; mdl_done = '0; force_valid = 1'b0;
    s0.x = 32'h3cc7d5cf; s0.x_dot = 32'h3c263435; s0.theta = 32'hbc9b0897; s0.theta_dot = 32'hbd2e64b9;
    seed_bank[0] = s0;
    for (int g = 1; g < PE; g++) seed_bank[g] = {32'h3f800000 + 32'(g), 32'(g), 32'hbf000000, 32'(g * 7)};
    for (int g = 0; g < PE; g++) seed_vec[g*SW +: SW] = seed_bank[g];

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_obs_valid", 128'(obs_valid), 128'd0);
    check_val("rst_act_ready", 128'(act_ready), 128'd0);
    check_val("rst_ena",       128'(cmpt_ena),  128'd0);
    check_val("rst_timeout",   128'(timeout),   128'd0);
    check_val("rst_cnt",       128'(step_cnt),  128'd0);
    check_val("rst_obs_sta",   128'(|obs_sta),  128'd0);
    rst = 1'b0;

    // Action outside WAIT_ACT is ignored
    act_valid = 1'b1;
    @(negedge clk);
    check_val("idle_act_ready", 128'(act_ready), 128'd0);
    check_val("idle_obs_valid", 128'(obs_valid), 128'd0);
    act_valid = 1'b0;

    // T1: start -> PUB in one cycle, seed observed
    do_start();
    check_val("t1_env0", obs_sta[127:0], 128'h3cc7d5cf_3c263435_bc9b0897_bd2e64b9);
    check_obs("t1");
    force_valid = 1'b1;
    @(negedge clk) force_valid = 1'b0;
    check_val("t1_stray_valid_cnt", 128'(step_cnt), 128'd0);
    check_obs("t1_stray");

    // T2: latency 5, reward 1
    step('0, 5, '1, '0);
    check_val("t2_ena_cyc", 128'(ena_cyc), 128'd6);
    check_val("t2_env0", obs_sta[127:0], 128'h3cc7d5cf_3c263435_bc9b0897_bd2e64ba);
    check_val("t2_cnt1", 128'(step_cnt), 128'd1);
    check_obs("t2");
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_val("t2_start_in_pub_cnt", 128'(step_cnt), 128'd1);
    check_obs("t2_start_in_pub");

    // T3: env3 terminates, auto-reseeded
    step(20'hAAAAA, 3, 20'h0F0F0, 20'h00008);
    check_val("t3_ena_cyc", 128'(ena_cyc), 128'd4);
    check_val("t3_done", 128'(obs_done), 128'h8);
    check_val("t3_env3_seed", obs_sta[3*SW +: SW], seed_bank[3]);
    check_obs("t3");

    // T5: Compute never answers -> timeout, then restart from ERR
    mdl_en = 1'b0;
    hs_act(20'h12345);
    k_to = -1;
    for (int k = 0; k < 200; k++) begin
      if (timeout) begin
        k_to = k;
        break;
      end
      @(negedge clk);
    end
    check_val("t5_tmo_cyc", 128'(k_to), 128'(TMO + 1));
    check_val("t5_err_ena", 128'(cmpt_ena), 128'd0);
    check_val("t5_err_obs_valid", 128'(obs_valid), 128'd0);
    act_valid = 1'b1;
    @(negedge clk) act_valid = 1'b0;
    check_val("t5_err_act_ready", 128'(act_ready), 128'd0);
    check_val("t5_sticky", 128'(timeout), 128'd1);
    mdl_en = 1'b1;
    do_start();
    check_val("t5_cleared", 128'(timeout), 128'd0);
    check_obs("t5_restart");

    // T4: truncation at MAX_STEPS
    for (int i = 0; i < MAXS - 1; i++) step(PE'($urandom), 1, PE'($urandom), '0);
    check_obs("t4_499");
    step(PE'($urandom), 1, PE'($urandom), '0);
    check_val("t4_500_done", 128'(obs_done), 128'hFFFFF);
    check_obs("t4_500");
    step(PE'($urandom), 2, PE'($urandom), '0);
    check_val("t4_501_done", 128'(obs_done), 128'd0);
    check_obs("t4_501");

    // T6: stalled observation stays stable, then reset mid WAIT_RES
    snap   = obs_sta;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (obs_sta !== snap || obs_valid !== 1'b1) stable = 1'b0;
    end
    check_val("t6_stall_stable", 128'(stable), 128'd1);
    mdl_lat = 20;
    hs_act(20'h0F00F);
    repeat (3) @(negedge clk);
    check_val("t6_mid_ena", 128'(cmpt_ena), 128'd1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_val("t6_obs_valid", 128'(obs_valid), 128'd0);
    check_val("t6_ena",       128'(cmpt_ena),  128'd0);
    check_val("t6_cnt",       128'(step_cnt),  128'd0);
    check_val("t6_obs_sta",   128'(|obs_sta),  128'd0);
    check_val("t6_cmpt_act",  128'(cmpt_act),  128'd0);
    check_val("t6_rwd_done",  128'({obs_rwd, obs_done}), 128'd0);
    force_valid = 1'b1;
    @(negedge clk) force_valid = 1'b0;
    check_val("t6_late_valid_cnt", 128'(step_cnt), 128'd0);
    check_val("t6_late_valid_obs", 128'(obs_valid), 128'd0);

    // i_obs_ready held high: PUB lasts one cycle
    do_start();
    obs_ready = 1'b1;
    @(negedge clk);
    check_val("held_ready_obs_valid", 128'(obs_valid), 128'd0);
    check_val("held_ready_act_ready", 128'(act_ready), 128'd1);
    obs_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
